circle_engine: RTL and testbench

- Rasterises circle outlines into the DRAM framebuffer using the midpoint algorithm.
- Sits directly downstream of the graphics command processor and consumes its CE_* interface (color, arguments, trigger, frame).
- Drives the shared DRAM request path: address FIFO (af) and write-data FIFO (wdf).
- Each pixel is written as one 256-bit burst: one af entry plus two 128-bit wdf entries, with byte masks confining the write to that one pixel.

---
 rtl/circle_engine_if.sv | 29 ++
 rtl/circle_engine.sv | 149 ++++++++++++++
 tb/tb_circle_engine.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/circle_engine_if.sv
// Command-processor (CE_*) inputs and DRAM request-FIFO outputs of the circle rasteriser.
interface circle_engine_if;
    logic         ready;
    logic [23:0]  color;
    logic         color_valid;
    logic [31:0]  arguments;
    logic         arguments_valid;
    logic         trigger;
    logic [31:0]  frame;
    logic         af_full;
    logic         wdf_full;
    logic         af_wr_en;
    logic [30:0]  af_addr_din;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    modport master (
        input  ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din,
        output color, color_valid, arguments, arguments_valid, trigger, frame,
               af_full, wdf_full
    );

    modport slave (
        output ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din,
        input  color, color_valid, arguments, arguments_valid, trigger, frame,
               af_full, wdf_full
    );
endinterface

// File: rtl/circle_engine.sv
// Midpoint circle rasteriser: walks the eight octants per step and writes each
// visible pixel as one masked 256-bit DRAM burst (one af entry, two wdf words).
module circle_engine #(
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 600
) (
    input logic            clk,
    input logic            rst,
    circle_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, PLOT_A, PLOT_B, STEP} state_t;

    state_t state, state_next;

    logic [23:0]        color_q;
    logic [9:0]         cx_q, cy_q, r_q;
    logic [5:0]         frame_q;
    logic signed [11:0] x_q, y_q, err_q;
    logic [2:0]         oct_q;

    logic signed [11:0] cx, cy, px, py;
    logic signed [11:0] y_inc, x_dec, x_next, err_step;
    logic               visible;
    logic [15:0]        pix_mask;
    logic [127:0]       pix_data;

    // Only cx/cy/r and frame[27:22] ever reach the address; the rest is dropped.
    logic unused_bits;
    assign unused_bits = ^{bus.arguments[11:10], bus.frame[31:28], bus.frame[21:0]};

    assign cx = $signed({2'b00, cx_q});
    assign cy = $signed({2'b00, cy_q});

    always_comb begin
        px = cx;
        py = cy;
        case (oct_q)
            3'd0:    begin px = cx + x_q; py = cy + y_q; end
            3'd1:    begin px = cx + y_q; py = cy + x_q; end
            3'd2:    begin px = cx - y_q; py = cy + x_q; end
            3'd3:    begin px = cx - x_q; py = cy + y_q; end
            3'd4:    begin px = cx - x_q; py = cy - y_q; end
            3'd5:    begin px = cx - y_q; py = cy - x_q; end
            3'd6:    begin px = cx + y_q; py = cy - x_q; end
            default: begin px = cx + x_q; py = cy - y_q; end
        endcase
    end

    assign visible  = !px[11] && !py[11] &&
                      (px < $signed(12'(SCREEN_W))) && (py < $signed(12'(SCREEN_H)));
    assign pix_mask = ~(16'h000F << {px[1:0], 2'b00});
    assign pix_data = {4{8'h00, color_q}};

    // Midpoint step uses the already-incremented Y (and decremented X) in the error update.
    assign y_inc    = y_q + 12'sd1;
    assign x_dec    = x_q - 12'sd1;
    assign x_next   = err_q[11] ? x_q : x_dec;
    assign err_step = err_q[11] ? (err_q + (y_inc <<< 1) + 12'sd1)
                                : (err_q + ((y_inc - x_dec) <<< 1) + 12'sd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            color_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            r_q     <= '0;
            frame_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= '0;
            oct_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.color_valid) color_q <= bus.color;
                    if (bus.arguments_valid) begin
                        cx_q    <= bus.arguments[31:22];
                        cy_q    <= bus.arguments[21:12];
                        r_q     <= bus.arguments[9:0];
                        frame_q <= bus.frame[27:22];
                    end else if (bus.trigger) begin
                        frame_q <= bus.frame[27:22];
                    end
                end
                INIT: begin
                    x_q   <= $signed({2'b00, r_q});
                    y_q   <= '0;
                    err_q <= 12'sd1 - $signed({2'b00, r_q});
                    oct_q <= '0;
                end
                PLOT_A: if (!visible) oct_q <= oct_q + 3'd1;
                PLOT_B: if (!bus.wdf_full) oct_q <= oct_q + 3'd1;
                STEP: begin
                    y_q   <= y_inc;
                    x_q   <= x_next;
                    err_q <= err_step;
                    oct_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Pushes are combinational on the full flags so none can land in a full cycle.
    always_comb begin
        state_next       = state;
        bus.ready        = 1'b0;
        bus.af_wr_en     = 1'b0;
        bus.wdf_wr_en    = 1'b0;
        bus.af_addr_din  = '0;
        bus.wdf_din      = '0;
        bus.wdf_mask_din = 16'hFFFF;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.arguments_valid || bus.trigger) state_next = INIT;
            end
            INIT: state_next = PLOT_A;
            PLOT_A: begin
                if (!visible) begin
                    state_next = (oct_q == 3'd7) ? STEP : PLOT_A;
                end else if (!bus.af_full && !bus.wdf_full) begin
                    bus.af_wr_en     = 1'b1;
                    bus.wdf_wr_en    = 1'b1;
                    bus.af_addr_din  = {6'b0, frame_q, py[9:0], px[9:3], 2'b00};
                    bus.wdf_din      = pix_data;
                    bus.wdf_mask_din = px[2] ? 16'hFFFF : pix_mask;
                    state_next       = PLOT_B;
                end
            end
            PLOT_B: begin
                if (!bus.wdf_full) begin
                    bus.wdf_wr_en    = 1'b1;
                    bus.wdf_din      = pix_data;
                    bus.wdf_mask_din = px[2] ? pix_mask : 16'hFFFF;
                    state_next       = (oct_q == 3'd7) ? STEP : PLOT_A;
                end
            end
            STEP: state_next = (x_next >= y_inc) ? PLOT_A : IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) begin
            bus.af_wr_en  = 1'b0;
            bus.wdf_wr_en = 1'b0;
        end
    end
endmodule

// File: tb/tb_circle_engine.sv
// Bench for circle_engine: a reference midpoint model fills a push scoreboard that a
// negedge monitor drains; vectors cover single pixel, clipping, stalls and protocol.
`timescale 1ns/1ps
module tb_circle_engine;
    logic clk = 1'b0;
    logic rst;

    circle_engine_if bus ();

    circle_engine #(.SCREEN_W(800), .SCREEN_H(600)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [30:0]  af_exp_q [$];
    logic [143:0] wdf_exp_q [$];
    logic [30:0]  af_log [$];
    int           af_count = 0;
    int           wdf_count = 0;

    logic [23:0] sh_color = '0;
    logic [31:0] sh_args  = '0;
    logic [31:0] sh_frame = '0;

    typedef struct {
        string       name;
        logic [23:0] color;
        logic [31:0] args;
        logic [31:0] frame;
        int          exp_af;
        logic [30:0] exp_first_addr;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [159:0] actual,
                               input logic [159:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] mk_args(input int cx, input int cy, input int r);
        logic [31:0] a;
        a = 32'h0;
        a[31:22] = cx[9:0];
        a[21:12] = cy[9:0];
        a[9:0]   = r[9:0];
        return a;
    endfunction

    function automatic logic [15:0] nib_mask(input int k);
        return 16'hFFFF ^ (16'h000F << (4 * k));
    endfunction

    task automatic model_draw(input logic [31:0] args, input logic [31:0] frm,
                              input logic [23:0] col);
        int cx, cy, r, x, y, err, px, py, k, hi;
        int dx [8];
        int dy [8];
        logic [127:0] data;
        cx   = int'(args[31:22]);
        cy   = int'(args[21:12]);
        r    = int'(args[9:0]);
        data = {4{8'h00, col}};
        x = r; y = 0; err = 1 - r;
        while (x >= y) begin
            dx = '{x, y, -y, -x, -x, -y, y, x};
            dy = '{y, x, x, y, -y, -x, -x, -y};
            for (int o = 0; o < 8; o++) begin
                px = cx + dx[o];
                py = cy + dy[o];
                if (px >= 0 && py >= 0 && px < 800 && py < 600) begin
                    k  = px % 4;
                    hi = (px / 4) % 2;
                    af_exp_q.push_back({6'b0, frm[27:22], py[9:0], px[9:3], 2'b00});
                    wdf_exp_q.push_back({(hi == 1) ? 16'hFFFF : nib_mask(k), data});
                    wdf_exp_q.push_back({(hi == 1) ? nib_mask(k) : 16'hFFFF, data});
                end
            end
            y++;
            if (err < 0) err += 2 * y + 1;
            else begin
                x--;
                err += 2 * (y - x) + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.af_full === 1'b1) checkOutput("af_push_while_full", bus.af_wr_en, 1'b0);
        if (bus.wdf_full === 1'b1) checkOutput("wdf_push_while_full", bus.wdf_wr_en, 1'b0);
        if (bus.af_wr_en === 1'b1) begin
            af_count++;
            af_log.push_back(bus.af_addr_din);
            if (af_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL af_unexpected: got push addr %0h required no push", bus.af_addr_din);
            end else checkOutput("af_addr", bus.af_addr_din, af_exp_q.pop_front());
        end
        if (bus.wdf_wr_en === 1'b1) begin
            wdf_count++;
            if (wdf_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL wdf_unexpected: got push mask %0h required no push", bus.wdf_mask_din);
            end else checkOutput("wdf_word", {bus.wdf_mask_din, bus.wdf_din}, wdf_exp_q.pop_front());
        end
    end

    task automatic applyStimulus(input logic [23:0] col, input bit cv, input logic [31:0] args,
                                 input bit av, input bit trig, input logic [31:0] frm,
                                 input bit accepted);
        bus.color           = col;
        bus.color_valid     = cv;
        bus.arguments       = args;
        bus.arguments_valid = av;
        bus.trigger         = trig;
        bus.frame           = frm;
        if (accepted) begin
            if (cv) sh_color = col;
            if (av) begin
                sh_args  = args;
                sh_frame = frm;
            end else if (trig) sh_frame = frm;
            if (av || trig) model_draw(sh_args, sh_frame, sh_color);
        end
        @(posedge clk);
        #1;
        bus.color_valid     = 1'b0;
        bus.arguments_valid = 1'b0;
        bus.trigger         = 1'b0;
    endtask

    task automatic waitReady(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ready !== 1'b1 && n < budget);
        checkOutput({name, "_ready"}, bus.ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitAfPushes(input string name, input int target, input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (af_count < target && n < budget);
        checkOutput({name, "_reached"}, (af_count >= target), 1'b1);
        #1;
    endtask

    task automatic checkDraw(input string name, input int af_base, input int wdf_base,
                             input int exp_af, input logic [30:0] exp_first);
        checkOutput({name, "_af_count"}, 160'(af_count - af_base), 160'(exp_af));
        checkOutput({name, "_wdf_count"}, 160'(wdf_count - wdf_base), 160'(2 * exp_af));
        if (af_log.size() > 0) checkOutput({name, "_first_addr"}, af_log[0], exp_first);
        checkOutput({name, "_sb_empty"}, 160'(af_exp_q.size() + wdf_exp_q.size()), 160'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion required finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int af_base, wdf_base, af_snap, wdf_snap;

        vecs[0] = '{"single_pixel", 24'h00FF00, mk_args(100, 50, 0), 32'h10400000, 8, 31'h86430};
        vecs[1] = '{"r1_at_10_10", 24'h123456, mk_args(10, 10, 1), 32'h00000000, 8, 31'h01404};
        vecs[2] = '{"clip_origin", 24'hABCDEF, mk_args(0, 0, 5), 32'h00000000, 10, 31'h00000};
        vecs[3] = '{"clip_corner", 24'hFF0000, mk_args(799, 599, 5), 32'h0FC00000, 10, 31'h1FCAF8C};
        vecs[4] = '{"r3_reserved", 24'h0000FF, mk_args(400, 300, 3) | 32'h00000C00, 32'h00C00000,
                    24, 31'h1A58C8};

        rst                 = 1'b1;
        bus.color           = '0;
        bus.color_valid     = 1'b0;
        bus.arguments       = '0;
        bus.arguments_valid = 1'b0;
        bus.trigger         = 1'b0;
        bus.frame           = '0;
        bus.af_full         = 1'b0;
        bus.wdf_full        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", bus.ready, 1'b1);
        checkOutput("reset_af_wr_en", bus.af_wr_en, 1'b0);
        checkOutput("reset_wdf_wr_en", bus.wdf_wr_en, 1'b0);
        checkOutput("reset_af_addr", bus.af_addr_din, 31'h0);
        checkOutput("reset_wdf_din", bus.wdf_din, 128'h0);
        checkOutput("reset_wdf_mask", bus.wdf_mask_din, 16'hFFFF);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            af_log.delete();
            af_base  = af_count;
            wdf_base = wdf_count;
            applyStimulus(vecs[i].color, 1'b1, vecs[i].args, 1'b1, 1'b0, vecs[i].frame, 1'b1);
            waitReady(vecs[i].name, 500);
            checkDraw(vecs[i].name, af_base, wdf_base, vecs[i].exp_af, vecs[i].exp_first_addr);
        end

        // Redraw of the last circle via trigger with stalls on both FIFOs.
        af_log.delete();
        af_base  = af_count;
        wdf_base = wdf_count;
        applyStimulus(24'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00C00000, 1'b1);
        waitAfPushes("stall_start", af_base + 3, 200);
        bus.af_full = 1'b1;
        af_snap = af_count;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("stall_af_frozen", 160'(af_count), 160'(af_snap));
        bus.af_full = 1'b0;
        waitAfPushes("stall_resume", af_snap + 1, 200);
        bus.wdf_full = 1'b1;
        wdf_snap = wdf_count;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_wdf_frozen", 160'(wdf_count), 160'(wdf_snap));
        bus.wdf_full = 1'b0;
        waitReady("stall", 500);
        checkDraw("stall", af_base, wdf_base, 24, 31'h1A58C8);

        // Commands while busy are ignored; trigger afterwards redraws the accepted circle.
        af_log.delete();
        af_base  = af_count;
        wdf_base = wdf_count;
        applyStimulus(24'h00AA00, 1'b1, mk_args(10, 10, 1), 1'b1, 1'b0, 32'h00400000, 1'b1);
        applyStimulus(24'h111111, 1'b1, mk_args(500, 500, 7), 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
        waitReady("busy_ignore", 500);
        checkDraw("busy_ignore", af_base, wdf_base, 8, 31'h081404);

        af_log.delete();
        af_base  = af_count;
        wdf_base = wdf_count;
        applyStimulus(24'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00800000, 1'b1);
        waitReady("trigger_redraw", 500);
        checkDraw("trigger_redraw", af_base, wdf_base, 8, 31'h101404);

        // Reset in the middle of a draw.
        af_base = af_count;
        applyStimulus(24'h445566, 1'b1, mk_args(400, 300, 5), 1'b1, 1'b0, 32'h0, 1'b1);
        waitAfPushes("rst_mid_start", af_base + 5, 200);
        rst = 1'b1;
        af_snap  = af_count;
        wdf_snap = wdf_count;
        @(posedge clk);
        #1;
        rst = 1'b0;
        af_exp_q.delete();
        wdf_exp_q.delete();
        sh_color = '0;
        sh_args  = '0;
        sh_frame = '0;
        @(negedge clk);
        checkOutput("rst_mid_ready", bus.ready, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("rst_mid_no_af", 160'(af_count), 160'(af_snap));
        checkOutput("rst_mid_no_wdf", 160'(wdf_count), 160'(wdf_snap));
        @(posedge clk);
        #1;

        // Latched state was cleared: trigger draws r=0 at the origin in color 0.
        af_log.delete();
        af_base  = af_count;
        wdf_base = wdf_count;
        applyStimulus(24'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        waitReady("post_reset", 500);
        checkDraw("post_reset", af_base, wdf_base, 8, 31'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
